// File: rtl/rcp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rcp_arbiter_pkg
// Brief   : Shared fixed-point format definitions for the reciprocal arbiter.
// Revision: 1.0
// ============================================================================
package rcp_arbiter_pkg;

  localparam int QM_DEF = 12;
  localparam int QN_DEF = 12;

  function automatic int fx_width(input int qm, input int qn);
    return qm + qn;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rcp_arbiter_reciprocal.sv
`default_nettype none
// ============================================================================
// Module  : rcp_arbiter_reciprocal
// Brief   : Combinational saturating 1/x on a signed Qm.n word.
// Revision: 1.0
// ============================================================================
module rcp_arbiter_reciprocal
  import rcp_arbiter_pkg::*;
#(
  parameter int M = QM_DEF,
  parameter int N = QN_DEF
) (
  input  logic [fx_width(M, N)-1:0] x_i,
  input  logic                      abs_i,
  output logic [fx_width(M, N)-1:0] y_o,
  output logic                      sat_o
);

  localparam int W  = fx_width(M, N);
  localparam int QW = W + 2 * N + 1;

  localparam logic [QW-1:0] ONE         = QW'(1);
  localparam logic [QW-1:0] NUM         = ONE << (2 * N);
  localparam logic [QW-1:0] MAX_POS     = (ONE << (W - 1)) - ONE;
  localparam logic [QW-1:0] MAX_NEG_MAG = ONE << (W - 1);

  logic          neg;
  logic          neg_out;
  logic [W-1:0]  mag;
  logic [QW-1:0] den;
  logic [QW-1:0] quo;

  always_comb begin : p_recip
    neg     = x_i[W-1];
    neg_out = neg & ~abs_i;
    mag     = neg ? (~x_i + W'(1)) : x_i;
    den     = QW'(mag);
    quo     = (mag == '0) ? '0 : (NUM / den);
    sat_o   = 1'b0;
    y_o     = '0;
    // Division by zero reports as positive-full-scale overflow
    if (mag == '0) begin
      sat_o = 1'b1;
      y_o   = {1'b0, {(W-1){1'b1}}};
    end else if (neg_out) begin
      if (quo > MAX_NEG_MAG) begin
        sat_o = 1'b1;
        y_o   = {1'b1, {(W-1){1'b0}}};
      end else begin
        y_o = W'(QW'(0) - quo);
      end
    end else if (quo > MAX_POS) begin
      sat_o = 1'b1;
      y_o   = {1'b0, {(W-1){1'b1}}};
    end else begin
      y_o = W'(quo);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rcp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rcp_arbiter
// Brief   : Round-robin arbiter sharing one reciprocal unit among NREQ users.
// Revision: 1.0
// ============================================================================
module rcp_arbiter
  import rcp_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int M      = QM_DEF,
  parameter int N      = QN_DEF,
  parameter int SETTLE = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*fx_width(M, N)-1:0] req_data,
  input  logic [NREQ-1:0]                req_abs,
  output logic [NREQ-1:0]                gnt,
  output logic [NREQ-1:0]                done,
  output logic [fx_width(M, N)-1:0]      o_data,
  output logic                           o_sat,
  output logic                           busy
);

  localparam int W  = fx_width(M, N);
  localparam int IW = $clog2(NREQ);
  localparam int CW = 3;

  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic            abs_q, abs_d;
  logic [IW-1:0]   last_q, last_d;
  logic [W-1:0]    data_q, data_d;
  logic            sat_q, sat_d;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [W-1:0]    rcp_y;
  logic            rcp_sat;

  // Only captured registers feed the divider, so requesters may change data freely
  rcp_arbiter_reciprocal #(
    .M (M),
    .N (N)
  ) u_reciprocal (
    .x_i   (opnd_q),
    .abs_i (abs_q),
    .y_o   (rcp_y),
    .sat_o (rcp_sat)
  );

  always_comb begin : p_rr
    elig      = req & ~((state_q == ST_DONE) ? gnt_q : '0);
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin : p_state_reg
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_found) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = win_found ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin : p_dp_next
    gnt_d  = gnt_q;
    done_d = '0;
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    abs_d  = abs_q;
    last_d = last_q;
    data_d = data_q;
    sat_d  = sat_q;
    if (flush) begin
      gnt_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (win_found) begin
            gnt_d  = NREQ'(1) << win_idx;
            opnd_d = req_data[win_idx*W +: W];
            abs_d  = req_abs[win_idx];
            cnt_d  = CNT_LOAD;
            last_d = win_idx;
          end else begin
            gnt_d = '0;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            data_d = rcp_y;
            sat_d  = rcp_sat;
            done_d = gnt_q;
          end
        end
        default: gnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin : p_dp_reg
    if (!reset) begin
      gnt_q  <= '0;
      done_q <= '0;
      cnt_q  <= '0;
      opnd_q <= '0;
      abs_q  <= 1'b0;
      last_q <= IW'(NREQ - 1);
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      abs_q  <= abs_d;
      last_q <= last_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin : p_out
    busy = (state_q != ST_IDLE);
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign o_data = data_q;
  assign o_sat  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_rcp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rcp_arbiter
// Brief   : Scoreboard bench for rcp_arbiter in Q12.12 with four requesters.
// Revision: 1.0
// ============================================================================
module tb_rcp_arbiter;

  localparam int NREQ   = 4;
  localparam int M      = 12;
  localparam int N      = 12;
  localparam int W      = 24;
  localparam int SETTLE = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_abs;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [W-1:0]    o_data;
  logic            o_sat;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] last_data = '0;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] data;
    logic         sat;
  } exp_t;

  exp_t sb[$];

  rcp_arbiter #(
    .NREQ   (NREQ),
    .M      (M),
    .N      (N),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .req      (req),
    .req_data (req_data),
    .req_abs  (req_abs),
    .gnt      (gnt),
    .done     (done),
    .o_data   (o_data),
    .o_sat    (o_sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference 1/x in Q12.12: {sat, data}
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic ab);
    longint sx, mag, q;
    bit     neg;
    sx  = longint'($signed(x));
    mag = (sx < 0) ? -sx : sx;
    if (mag == 0) return {1'b1, 24'h7FFFFF};
    q   = (64'sd1 << 24) / mag;
    neg = (sx < 0) && !ab;
    if (neg) begin
      if (q > (64'sd1 << 23)) return {1'b1, 24'h800000};
      return {1'b0, 24'(-q)};
    end
    if (q > ((64'sd1 << 23) - 1)) return {1'b1, 24'h7FFFFF};
    return {1'b0, 24'(q)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && done !== 4'b0) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'h0);
      end else begin
        e = sb.pop_front();
        check_eq("done_idx", 32'(done), 32'(4'b0001 << e.idx));
        check_eq("sb_o_data", 32'(o_data), 32'(e.data));
        check_eq("sb_o_sat", 32'(o_sat), 32'(e.sat));
      end
    end
  end

  task automatic push_exp(input int idx, input logic [W-1:0] data, input logic ab);
    logic [W:0] m;
    m = model(data, ab);
    sb.push_back('{idx: 2'(idx), data: m[W-1:0], sat: m[W]});
    last_data = m[W-1:0];
  endtask

  task automatic run_op(input int idx, input logic [W-1:0] data, input logic ab, input bit mutate);
    int cyc;
    req_data[idx*W +: W] = data;
    req_abs[idx]         = ab;
    req[idx]             = 1'b1;
    push_exp(idx, data, ab);
    @(negedge clk);
    check_eq("grant", 32'(gnt), 32'(4'b0001 << idx));
    check_eq("busy_on", 32'(busy), 32'h1);
    if (mutate) begin
      req_data[idx*W +: W] = 24'h000400;
      req[idx]             = 1'b0;
    end
    cyc = 1;
    while (done === 4'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(SETTLE + 1));
    req[idx] = 1'b0;
    @(negedge clk);
    check_eq("idle_after", 32'(busy), 32'h0);
    check_eq("hold_data", 32'(o_data), 32'(last_data));
  endtask

  task automatic run_multi(input logic [NREQ-1:0] mask, input int first);
    int remaining, cyc, prev;
    remaining = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_data[i*W +: W] = 24'(32'h1000 * (i + 1));
        req_abs[i]         = 1'b0;
        remaining++;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (first + k) % NREQ;
      if (mask[i]) push_exp(i, req_data[i*W +: W], 1'b0);
    end
    req = req | mask;
    @(negedge clk);
    check_eq("multi_first_gnt", 32'(gnt), 32'(4'b0001 << first));
    cyc  = 1;
    prev = -1;
    while (remaining > 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done !== 4'b0) begin
        if (prev >= 0) check_eq("throughput", 32'(cyc - prev), 32'(SETTLE + 1));
        prev      = cyc;
        req       = req & ~done;
        remaining--;
      end
    end
    check_eq("multi_pending", 32'(remaining), 32'h0);
    @(negedge clk);
    check_eq("multi_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    req      = '0;
    req_data = '0;
    req_abs  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_data", 32'(o_data), 32'h0);
    check_eq("rst_sat", 32'(o_sat), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Basic 1/2.0, abs-mode with late operand change and req drop, signed result
    run_op(0, 24'h002000, 1'b0, 1'b0);
    check_eq("r034_data", 32'(o_data), 32'h000800);
    check_eq("r034_sat", 32'(o_sat), 32'h0);
    run_op(2, 24'hFFE000, 1'b1, 1'b1);
    check_eq("r035_data", 32'(o_data), 32'h000800);
    run_op(1, 24'hFFE000, 1'b0, 1'b0);
    check_eq("neg_data", 32'(o_data), 32'hFFF800);
    run_op(3, 24'h000000, 1'b0, 1'b0);
    check_eq("r037_zero_data", 32'(o_data), 32'h7FFFFF);
    check_eq("r037_zero_sat", 32'(o_sat), 32'h1);
    run_op(3, 24'h000400, 1'b0, 1'b0);
    check_eq("r037_data", 32'(o_data), 32'h004000);
    check_eq("r037_sat", 32'(o_sat), 32'h0);

    // A pulse that falls before any rising edge must not be granted
    #1 req[2] = 1'b1;
    #2 req[2] = 1'b0;
    @(negedge clk);
    check_eq("short_pulse_gnt", 32'(gnt), 32'h0);
    repeat (3) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'h0);
    check_eq("idle_data", 32'(o_data), 32'h004000);

    run_multi(4'b1111, 0);
    run_op(1, 24'h003000, 1'b0, 1'b0);

    // Flush landing on the cnt==0 edge
    req_data[0 +: W] = 24'h002000;
    req[0]           = 1'b1;
    @(negedge clk);
    check_eq("fl_grant", 32'(gnt), 32'h1);
    repeat (SETTLE - 1) @(negedge clk);
    flush            = 1'b1;
    req_data[0 +: W] = 24'h001000;
    @(negedge clk);
    check_eq("fl_done", 32'(done), 32'h0);
    check_eq("fl_busy", 32'(busy), 32'h0);
    check_eq("fl_gnt", 32'(gnt), 32'h0);
    check_eq("fl_hold", 32'(o_data), 32'(last_data));
    flush = 1'b0;
    push_exp(0, 24'h001000, 1'b0);
    @(negedge clk);
    check_eq("fl_regrant", 32'(gnt), 32'h1);
    begin
      int cyc;
      cyc = 1;
      while (done === 4'b0 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check_eq("fl_latency", 32'(cyc), 32'(SETTLE + 1));
    end
    req[0] = 1'b0;
    @(negedge clk);
    check_eq("fl_data", 32'(o_data), 32'h001000);

    // Asynchronous reset in the middle of WAIT
    req_data[3*W +: W] = 24'h002000;
    req[3]             = 1'b1;
    @(negedge clk);
    check_eq("rs_grant", 32'(gnt), 32'h8);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rs_gnt", 32'(gnt), 32'h0);
    check_eq("rs_done", 32'(done), 32'h0);
    check_eq("rs_busy", 32'(busy), 32'h0);
    check_eq("rs_data", 32'(o_data), 32'h0);
    check_eq("rs_sat", 32'(o_sat), 32'h0);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_multi(4'b0110, 1);
    check_eq("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
